// File: rtl/acc_layer_ctrl.sv
// Layer sequencer for the accumulator bank: latches a conv-layer config, gates systolic-array
// psum rows into all accumulator columns in lockstep, then waits for every column's last.
module acc_layer_ctrl #(
    parameter int NUM_COL       = 8,
    parameter int SIZE_W        = 5,
    parameter int CH_W          = 6,
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [SIZE_W-1:0]  cfg_ofmap_size_i,
    input  logic [CH_W-1:0]    cfg_ifmap_ch_i,
    input  logic               sa_valid_i,
    output logic               sa_ready_o,
    input  logic [NUM_COL-1:0] acc_pready_i,
    output logic [NUM_COL-1:0] acc_pvalid_o,
    output logic [SIZE_W-1:0]  acc_ofmap_size_o,
    output logic [CH_W-1:0]    acc_ifmap_ch_o,
    input  logic [NUM_COL-1:0] acc_last_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   beat_cnt_o
);

    localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [SIZE_W-1:0]    size_q, size_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     beat_q, beat_d;
    logic [NUM_COL-1:0]   seen_q, seen_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 err_q, err_d;

    logic cfg_bad;
    logic all_ready;
    logic xfer;
    logic all_last;

    // Handshakes are valid/ready: a transfer happens on a cycle where both are high; the
    // sender holds valid and its payload until that cycle. A row moves into all columns or none.
    assign cfg_bad   = (cfg_ofmap_size_i < SIZE_W'(2)) | cfg_ofmap_size_i[0]
                     | (cfg_ofmap_size_i > SIZE_W'(30)) | (cfg_ifmap_ch_i == '0);
    assign all_ready = &acc_pready_i;
    assign xfer      = (state_q == S_FEED) & sa_valid_i & all_ready;
    assign all_last  = &(seen_q | acc_last_i);

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        ch_d    = ch_q;
        total_d = total_q;
        beat_d  = beat_q;
        seen_d  = seen_q;
        err_d   = err_q;
        to_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        size_d  = cfg_ofmap_size_i;
                        ch_d    = cfg_ifmap_ch_i;
                        err_d   = 1'b0;
                        beat_d  = '0;
                        seen_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                total_d = CNT_W'(size_q) * CNT_W'(size_q) * CNT_W'(ch_q);
                state_d = S_FEED;
            end
            S_FEED: begin
                if (xfer) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (beat_q == total_q - CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
                // A column finishing before all rows were fed is flagged but not fatal.
                if (|acc_last_i) begin
                    err_d = 1'b1;
                end
            end
            S_DRAIN: begin
                seen_d = seen_q | acc_last_i;
                if (all_last) begin
                    state_d = S_DONE;
                end else if (to_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            ch_q    <= '0;
            total_q <= '0;
            beat_q  <= '0;
            seen_q  <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            ch_q    <= ch_d;
            total_q <= total_d;
            beat_q  <= beat_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready_o      = (state_q == S_IDLE);
    assign sa_ready_o       = (state_q == S_FEED) & all_ready;
    assign acc_pvalid_o     = {NUM_COL{xfer}};
    assign acc_ofmap_size_o = size_q;
    assign acc_ifmap_ch_o   = ch_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign err_o            = err_q;
    assign beat_cnt_o       = beat_q;

endmodule
